// File: rtl/bram_arbiter_if.sv
// ============================================================================
// Module   : bram_arbiter_if
// Brief    : Requester, BRAM and status signals for the two-port BRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                  i_req0;
   logic                  i_req1;
   logic [ADDR_WIDTH-1:0] i_addr0;
   logic [ADDR_WIDTH-1:0] i_addr1;
   logic                  i_write0;
   logic                  i_write1;
   logic [DATA_WIDTH-1:0] i_data0;
   logic [DATA_WIDTH-1:0] i_data1;
   logic                  o_gnt0;
   logic                  o_gnt1;
   logic                  o_rvalid0;
   logic                  o_rvalid1;
   logic [DATA_WIDTH-1:0] o_data0;
   logic [DATA_WIDTH-1:0] o_data1;
   logic [ADDR_WIDTH-1:0] o_bram_addr;
   logic [DATA_WIDTH-1:0] o_bram_data;
   logic                  o_bram_write;
   logic [DATA_WIDTH-1:0] i_bram_data;
   logic                  o_owner;
   logic                  o_busy;

   // Requesters plus the BRAM read-data return path
   modport master (
      output i_req0, i_req1, i_addr0, i_addr1, i_write0, i_write1,
             i_data0, i_data1, i_bram_data,
      input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_data0, o_data1,
             o_bram_addr, o_bram_data, o_bram_write, o_owner, o_busy
   );

   modport slave (
      input  i_req0, i_req1, i_addr0, i_addr1, i_write0, i_write1,
             i_data0, i_data1, i_bram_data,
      output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_data0, o_data1,
             o_bram_addr, o_bram_data, o_bram_write, o_owner, o_busy
   );
endinterface

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// Module   : bram_arbiter
// Brief    : Round-robin, burst-capped arbiter sharing one single-port BRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_BURST  = 4
) (
   input  wire logic     i_clk,
   input  wire logic     i_rst,
   bram_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] c_max_burst = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last;
   logic             r_owner;
   logic             r_rvalid0;
   logic             r_rvalid1;

   logic             w_own;
   logic             w_req_own;
   logic             w_req_oth;
   logic             w_win_valid;
   logic             w_win;
   state_t           w_next_state;
   logic [CNT_W-1:0] w_next_cnt;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;

   assign w_own     = (r_state == ST_OWN1);
   assign w_req_own = w_own ? bus.i_req1 : bus.i_req0;
   assign w_req_oth = w_own ? bus.i_req0 : bus.i_req1;

   always_comb begin
      w_win_valid  = 1'b0;
      w_win        = 1'b0;
      w_next_state = ST_IDLE;
      w_next_cnt   = '0;
      if (r_state == ST_IDLE) begin
         if (bus.i_req0 && bus.i_req1) begin
            w_win_valid = 1'b1;
            w_win       = ~r_last;
         end else if (bus.i_req0 || bus.i_req1) begin
            w_win_valid = 1'b1;
            w_win       = bus.i_req1;
         end
         if (w_win_valid) w_next_cnt = c_one;
      end else begin
         // Cap only bites when the other port is actually waiting
         if (w_req_own && (r_cnt < c_max_burst)) begin
            w_win_valid = 1'b1;
            w_win       = w_own;
            w_next_cnt  = r_cnt + c_one;
         end else if (w_req_oth) begin
            w_win_valid = 1'b1;
            w_win       = ~w_own;
            w_next_cnt  = c_one;
         end else if (w_req_own) begin
            w_win_valid = 1'b1;
            w_win       = w_own;
            w_next_cnt  = c_one;
         end
      end
      if (w_win_valid) w_next_state = w_win ? ST_OWN1 : ST_OWN0;
   end

   assign w_addr  = w_win ? bus.i_addr1 : bus.i_addr0;
   assign w_wdata = w_win ? bus.i_data1 : bus.i_data0;

   assign bus.o_gnt0       = w_win_valid & ~w_win;
   assign bus.o_gnt1       = w_win_valid &  w_win;
   assign bus.o_busy       = w_win_valid;
   assign bus.o_bram_addr  = w_addr;
   assign bus.o_bram_data  = w_wdata;
   assign bus.o_bram_write = w_win_valid & (w_win ? bus.i_write1 : bus.i_write0);
   assign bus.o_owner      = w_win_valid ? w_win : r_owner;
   assign bus.o_rvalid0    = r_rvalid0;
   assign bus.o_rvalid1    = r_rvalid1;
   assign bus.o_data0      = bus.i_bram_data;
   assign bus.o_data1      = bus.i_bram_data;

   // last resets to 1 so port 0 takes the first tie
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_last    <= 1'b1;
         r_owner   <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_cnt     <= w_next_cnt;
         r_rvalid0 <= bus.o_gnt0 & ~bus.i_write0;
         r_rvalid1 <= bus.o_gnt1 & ~bus.i_write1;
         if (w_win_valid) begin
            r_last  <= w_win;
            r_owner <= w_win;
         end
      end
   end
endmodule

`default_nettype wire
